// File: rtl/dff_arb_pkg.sv
// Shared constants for the round-robin register arbiter.
//   - arb_state_t / ST_* : FSM state encoding
//   - HOLD_W             : width of the hold counter (covers HOLD_CYCLES up to 255)
package dff_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_WRITE = 2'd1;
    localparam arb_state_t ST_HOLD  = 2'd2;
    localparam arb_state_t ST_DONE  = 2'd3;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/dff_register_bank.sv
// Shared DATA_W-bit storage register made of one D flip-flop per bit.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high clear
//   en     - load enable; q takes d on the rising edge while en is high
//   d      - load data
//   q      - stored value
module dff_register_bank #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        logic bit_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                bit_q <= 1'b0;
            end else if (en) begin
                bit_q <= d[i];
            end
        end

        assign q[i] = bit_q;
    end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters turns at writing one shared
// DATA_W-bit register. The winner is granted, its data is written in a single
// WRITE cycle, the grant is held for HOLD_CYCLES more cycles, and a DONE cycle
// pulses done before the arbiter returns to IDLE.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; pick the next requester after last_winner
// WRITE | grant[winner]; shared register loads winner's data at exit
// HOLD  | grant held; counter runs 0..HOLD_CYCLES-1
// DONE  | grant held, done=1; winner becomes last_winner at exit
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-high reset
//   req      - per-requester request
//   req_data - packed write data, requester i at [i*DATA_W +: DATA_W]
//   grant    - one-hot grant, zero when idle
//   done     - one-cycle end-of-transaction pulse
//   busy     - high outside IDLE
//   reg_q    - shared register contents
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      done,
    output logic                      busy,
    output logic [DATA_W-1:0]         reg_q
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  last_winner;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic              reg_en;
    logic [DATA_W-1:0] wr_data;

    // Index increment that wraps at NUM_REQ, which need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // First set request scanning upward from the slot after the last winner.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = wrap_inc(last_winner);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (found) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (HOLD_CYCLES > 0) ? ST_HOLD : ST_DONE;
            ST_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt    <= '0;
            winner      <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (state == ST_IDLE && found) begin
                winner <= pick;
            end
            if (state == ST_WRITE) begin
                hold_cnt <= '0;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state == ST_DONE) begin
                last_winner <= winner;
            end
        end
    end

    always_comb begin
        grant  = '0;
        busy   = (state != ST_IDLE);
        done   = (state == ST_DONE);
        reg_en = (state == ST_WRITE);
        if (state != ST_IDLE) begin
            grant[winner] = 1'b1;
        end
    end

    assign wr_data = req_data[int'(winner)*DATA_W +: DATA_W];

    dff_register_bank #(
        .DATA_W (DATA_W)
    ) u_bank (
        .clock (clock),
        .reset (reset),
        .en    (reg_en),
        .d     (wr_data),
        .q     (reg_q)
    );

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: vector table, hand-written corner sequences, and
// random traffic against a transaction-level reference model. A second
// instance is built with HOLD_CYCLES=0.
module tb_dff_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic           done;
    logic           busy;
    logic [W-1:0]   reg_q;

    logic [N-1:0]   req_h0;
    logic [N*W-1:0] data_h0;
    logic [N-1:0]   grant_h0;
    logic           done_h0;
    logic           busy_h0;
    logic [W-1:0]   reg_h0;

    always #5 clock = ~clock;

    dff_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(H)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .done     (done),
        .busy     (busy),
        .reg_q    (reg_q)
    );

    dff_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(0)) dut_h0 (
        .clock    (clock),
        .reset    (reset),
        .req      (req_h0),
        .req_data (data_h0),
        .grant    (grant_h0),
        .done     (done_h0),
        .busy     (busy_h0),
        .reg_q    (reg_h0)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a transaction is a run of H+2 granted cycles; the
    // register takes the winner's data at the end of the first one, done is
    // the last one.
    bit         m_active;
    int         m_age;
    int         m_win;
    int         m_last;
    logic [W-1:0] m_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_age    = 0;
        m_win    = 0;
        m_last   = N - 1;
        m_reg    = '0;
    endtask

    task automatic model_edge();
        int c;
        if (reset) begin
            model_reset();
        end else if (!m_active) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (req[c]) begin
                        m_win = c;
                        break;
                    end
                end
                m_active = 1'b1;
                m_age    = 0;
            end
        end else begin
            if (m_age == 0) m_reg = req_data[m_win*W +: W];
            if (m_age == H + 1) begin
                m_active = 1'b0;
                m_last   = m_win;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = m_active ? (N'(1) << m_win) : '0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_done", 32'(done), 32'(m_active && m_age == H + 1));
        chk("model_busy", 32'(busy), 32'(m_active));
        chk("model_reg_q", 32'(reg_q), 32'(m_reg));
    endtask

    // One clock: model samples the same edge as the DUT, checks at negedge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] g;
        logic         d;
        logic         b;
        logic [W-1:0] r;
    } vec_t;

    vec_t tbl[25];
    int   wins[$];
    logic [W-1:0] regs[$];
    int   n_done;
    logic [N-1:0] prev_g;

    initial begin
        tbl[0]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 8'hA5};
        tbl[2]  = '{4'b0000, 4'b0100, 1'b0, 1'b1, 8'hA5};
        tbl[3]  = '{4'b0000, 4'b0100, 1'b1, 1'b1, 8'hA5};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5};
        tbl[5]  = '{4'b0001, 4'b0001, 1'b0, 1'b1, 8'hA5};
        tbl[6]  = '{4'b0000, 4'b0001, 1'b0, 1'b1, 8'h10};
        tbl[7]  = '{4'b0000, 4'b0001, 1'b0, 1'b1, 8'h10};
        tbl[8]  = '{4'b0000, 4'b0001, 1'b1, 1'b1, 8'h10};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 8'h10};
        tbl[10] = '{4'b1111, 4'b0010, 1'b0, 1'b1, 8'h10};
        tbl[11] = '{4'b1111, 4'b0010, 1'b0, 1'b1, 8'h11};
        tbl[12] = '{4'b0011, 4'b0010, 1'b0, 1'b1, 8'h11};
        tbl[13] = '{4'b0011, 4'b0010, 1'b1, 1'b1, 8'h11};
        tbl[14] = '{4'b0011, 4'b0000, 1'b0, 1'b0, 8'h11};
        tbl[15] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 8'h11};
        tbl[16] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 8'h10};
        tbl[17] = '{4'b0011, 4'b0001, 1'b0, 1'b1, 8'h10};
        tbl[18] = '{4'b0011, 4'b0001, 1'b1, 1'b1, 8'h10};
        tbl[19] = '{4'b0011, 4'b0000, 1'b0, 1'b0, 8'h10};
        tbl[20] = '{4'b0011, 4'b0010, 1'b0, 1'b1, 8'h10};
        tbl[21] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 8'h11};
        tbl[22] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 8'h11};
        tbl[23] = '{4'b0000, 4'b0010, 1'b1, 1'b1, 8'h11};
        tbl[24] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11};

        // Reset and idle
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_h0   = '0;
        data_h0  = '0;
        model_reset();
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_reg_q", 32'(reg_q), 32'h0);
        @(negedge clock);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // HOLD_CYCLES=0 build: WRITE then DONE, two granted cycles
        req_h0  = 4'b0100;
        data_h0 = 32'h005A_0000;
        step();
        chk("h0_w_grant", 32'(grant_h0), 32'h4);
        chk("h0_w_done", 32'(done_h0), 32'h0);
        chk("h0_w_busy", 32'(busy_h0), 32'h1);
        req_h0 = '0;
        step();
        chk("h0_d_grant", 32'(grant_h0), 32'h4);
        chk("h0_d_done", 32'(done_h0), 32'h1);
        chk("h0_d_reg", 32'(reg_h0), 32'h5A);
        step();
        chk("h0_i_grant", 32'(grant_h0), 32'h0);
        chk("h0_i_busy", 32'(busy_h0), 32'h0);
        chk("h0_i_done", 32'(done_h0), 32'h0);

        // Vector table: single request, rotation, fairness after a win
        req_data = 32'h13A5_1110;
        for (int i = 0; i < 25; i++) begin
            req = tbl[i].req;
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("tbl%0d_reg_q", i), 32'(reg_q), 32'(tbl[i].r));
        end

        // Full contention from reset: 0,1,2,3,0 every 5 cycles
        reset = 1'b1;
        model_reset();
        step();
        reset    = 1'b0;
        req_data = 32'h1312_1110;
        req      = 4'b1111;
        n_done   = 0;
        for (int c = 0; c < 25; c++) begin
            prev_g = grant;
            step();
            if (grant != '0 && prev_g == '0) begin
                for (int b = 0; b < N; b++) if (grant[b]) wins.push_back(b);
            end
            if (done) begin
                n_done++;
                regs.push_back(reg_q);
            end
        end
        chk("rot_done_count", 32'(n_done), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rot_win%0d", i), (i < wins.size()) ? 32'(wins[i]) : 32'hFFFF_FFFF, 32'(i % 4));
            chk($sformatf("rot_reg%0d", i), (i < regs.size()) ? 32'(regs[i]) : 32'hFFFF_FFFF, 32'h10 + 32'(i % 4));
        end

        // Reset during HOLD
        req = '0;
        repeat (3) step();
        req = 4'b0010;
        step();
        step();
        req = '0;
        chk("mid_pre_grant", 32'(grant), 32'h2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_grant", 32'(grant), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_done", 32'(done), 32'h0);
        chk("mid_reg_q", 32'(reg_q), 32'h0);
        step();
        reset = 1'b0;
        req   = 4'b0010;
        step();
        chk("post_rst_grant", 32'(grant), 32'h2);
        req = '0;
        repeat (5) step();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            req      = ($urandom_range(0, 9) < 3) ? '0 : N'($urandom_range(0, 15));
            req_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before t=200000");
        $fatal(1);
    end

endmodule
